// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and per-stage payload bundles.
// The state encoding equals the number of held entries, so occupancy is the state itself.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Example MEM/WB bundle; callers pack it into the WIDTH-bit payload.
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  localparam int MEM_WB_WIDTH = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline register with a two-entry skid buffer and flush.
// in_ready and out_valid are decoded from the state register only, so no input reaches an output.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state_reg;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign occupancy = state_reg;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      if (CLEAR_DATA) begin
        main_reg <= '0;
        skid_reg <= '0;
      end
    end else if (flush) begin
      // Any coincident transfers are considered complete; the data is discarded.
      state_reg <= EMPTY;
      if (CLEAR_DATA) begin
        main_reg <= '0;
        skid_reg <= '0;
      end
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_reg  <= in_data;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_reg <= in_data;
          end else if (in_fire) begin
            skid_reg  <= in_data;
            state_reg <= FULL;
          end else if (out_fire) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the head can move.
          if (out_fire) begin
            main_reg  <= skid_reg;
            state_reg <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: one instance clears data on reset/flush, the other keeps stale data.
// Both instances see identical stimulus; expected values are hand-computed per step.
module tb_pipe_skid_stage;

  localparam int WIDTH = 32;
  localparam logic [31:0] A = 32'h0000_00A1;
  localparam logic [31:0] B = 32'h0000_00B2;
  localparam logic [31:0] C = 32'h0000_00C3;
  localparam logic [31:0] D = 32'h0000_00D4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             stall;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;

  logic             in_ready_c,  out_valid_c;
  logic [WIDTH-1:0] out_data_c;
  logic [1:0]       occupancy_c;
  logic             in_ready_k,  out_valid_k;
  logic [WIDTH-1:0] out_data_k;
  logic [1:0]       occupancy_k;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(WIDTH), .CLEAR_DATA(1'b1)) dut_clear (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready_c),
    .in_data   (in_data),
    .out_valid (out_valid_c),
    .out_ready (out_ready),
    .out_data  (out_data_c),
    .occupancy (occupancy_c)
  );

  pipe_skid_stage #(.WIDTH(WIDTH), .CLEAR_DATA(1'b0)) dut_keep (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready_k),
    .in_data   (in_data),
    .out_valid (out_valid_k),
    .out_ready (out_ready),
    .out_data  (out_data_k),
    .occupancy (occupancy_k)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    step();
    in_data   = B;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", 32'(out_valid_c), 32'd0);
    check("rst_in_ready",  32'(in_ready_c),  32'd1);
    check("rst_occupancy", 32'(occupancy_c), 32'd0);
    check("rst_out_data",  out_data_c,       32'd0);
    check("rst_keep_occ",  32'(occupancy_k), 32'd0);

    // Streaming: one transfer per cycle, occupancy stays at one.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      step();
      check($sformatf("stream_data_%0d", i), out_data_c, 32'(i));
      check($sformatf("stream_occ_%0d", i), 32'(occupancy_c), 32'd1);
      check($sformatf("stream_ready_%0d", i), 32'(in_ready_c), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_occ", 32'(occupancy_c), 32'd0);

    // Skid fill and release.
    fill_ab();
    check("skid_occ",      32'(occupancy_c), 32'd2);
    check("skid_in_ready", 32'(in_ready_c),  32'd0);
    check("skid_head",     out_data_c,       A);
    out_ready = 1'b1;
    step();
    check("skid_rel_data",  out_data_c,       B);
    check("skid_rel_ready", 32'(in_ready_c),  32'd1);
    check("skid_rel_occ",   32'(occupancy_c), 32'd1);
    step();
    check("skid_empty_valid", 32'(out_valid_c), 32'd0);

    // Stall masks the output transfer while FULL.
    fill_ab();
    out_ready = 1'b1;
    stall     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_head_%0d", i), out_data_c, A);
      check($sformatf("stall_occ_%0d", i), 32'(occupancy_c), 32'd2);
    end
    stall = 1'b0;
    step();
    check("unstall_data", out_data_c,       B);
    check("unstall_occ",  32'(occupancy_c), 32'd1);
    step();
    check("unstall_empty", 32'(occupancy_c), 32'd0);

    // Flush while FULL with a coincident input C.
    fill_ab();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = C;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("flush_occ",        32'(occupancy_c), 32'd0);
    check("flush_valid",      32'(out_valid_c), 32'd0);
    check("flush_data_clear", out_data_c,       32'd0);
    check("flush_in_ready",   32'(in_ready_c),  32'd1);
    check("flush_keep_occ",   32'(occupancy_k), 32'd0);
    check("flush_keep_valid", 32'(out_valid_k), 32'd0);
    check("flush_keep_stale", out_data_k,       A);
    step();
    check("flush_no_c_valid", 32'(out_valid_c), 32'd0);

    // Simultaneous load and deliver in ONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    step();
    check("simul_head_a", out_data_c, A);
    in_data   = D;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    check("simul_data_d",   out_data_c,       D);
    check("simul_occ",      32'(occupancy_c), 32'd1);
    check("simul_keep_d",   out_data_k,       D);
    step();
    check("simul_drain_occ", 32'(occupancy_c), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
